// File: rtl/upsp_pkg.sv
// Shared types and default geometry for the upsampler output stage.
package upsp_pkg;

  localparam int UPSP_DATA_WIDTH = 24;
  localparam int DST_IMG_WIDTH   = 3840;
  localparam int DST_IMG_HEIGHT  = 2160;

  // Raster counters are sized for the largest supported geometry, not the default.
  localparam int RASTER_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } upsp_pix_t;

  typedef logic [RASTER_W-1:0] col_t;
  typedef logic [RASTER_W-1:0] row_t;

endpackage

// File: rtl/upsp_out_fifo_if.sv
// Pixel handshake bundle: bicubic result port in, access_control write port out.
interface upsp_out_fifo_if #(
  parameter int DW = upsp_pkg::UPSP_DATA_WIDTH
);

  logic          bcci_rsp_valid;
  logic [DW-1:0] bcci_rsp_data;
  logic          bf_rsp_ready;
  logic          upsp_ac_wrt;
  logic [DW-1:0] upsp_ac_wdata;
  logic          upsp_ac_eol;
  logic          upsp_ac_eof;
  logic          ac_upsp_wready;

  // master: surrounding system (pixel producer + write consumer); slave: the FIFO.
  modport master (
    output bcci_rsp_valid, bcci_rsp_data, ac_upsp_wready,
    input  bf_rsp_ready, upsp_ac_wrt, upsp_ac_wdata, upsp_ac_eol, upsp_ac_eof
  );

  modport slave (
    input  bcci_rsp_valid, bcci_rsp_data, ac_upsp_wready,
    output bf_rsp_ready, upsp_ac_wrt, upsp_ac_wdata, upsp_ac_eol, upsp_ac_eof
  );

endinterface

// File: rtl/upsp_fifo_ram.sv
// DEPTH x DW register array: one synchronous write port, asynchronous read port.
// Storage is not reset; the owner masks the read data while the FIFO is empty.
module upsp_fifo_ram #(
  parameter int  DW    = upsp_pkg::UPSP_DATA_WIDTH,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/upsp_out_fifo.sv
// Elastic FWFT output FIFO tagging pixels with eol/eof; push visible next cycle, ready = !full.
// Optional OUTFIFO_STAT_EN adds high-water mark and stall-cycle statistics.
module upsp_out_fifo #(
  parameter int  UPSP_DATA_WIDTH = upsp_pkg::UPSP_DATA_WIDTH,
  parameter int  FIFO_DEPTH      = 16,
  parameter int  DST_IMG_WIDTH   = upsp_pkg::DST_IMG_WIDTH,
  parameter int  DST_IMG_HEIGHT  = upsp_pkg::DST_IMG_HEIGHT,
  localparam int LVL_W           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  upsp_out_fifo_if.slave    bus,
  output logic              frame_done,
  output logic [LVL_W-1:0]  fifo_level
`ifdef OUTFIFO_STAT_EN
  ,
  output logic [LVL_W-1:0]  fifo_hwm,
  output logic [31:0]       stall_cnt
`endif
);

  import upsp_pkg::*;

  localparam int   PTR_W    = $clog2(FIFO_DEPTH);
  localparam col_t COL_LAST = col_t'(DST_IMG_WIDTH - 1);
  localparam row_t ROW_LAST = row_t'(DST_IMG_HEIGHT - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  col_t             col_q, col_d;
  row_t             row_q, row_d;
  logic             frame_done_q, frame_done_d;

  logic                       full;
  logic                       head_vld;
  logic                       head_eol;
  logic                       head_eof;
  logic                       push_vld;
  logic                       pop_vld;
  logic [UPSP_DATA_WIDTH-1:0] head_dat;

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign head_vld = (level_q != '0);
  assign head_eol = head_vld & (col_q == COL_LAST);
  assign head_eof = head_eol & (row_q == ROW_LAST);

  // Flush wins: the pixel offered and any pop in a flush cycle are discarded.
  assign push_vld = bus.bcci_rsp_valid & ~full & ~flush;
  assign pop_vld  = head_vld & bus.ac_upsp_wready & ~flush;

  upsp_fifo_ram #(
    .DW    (UPSP_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_vld),
    .wr_addr (wr_ptr_q),
    .wr_dat  (bus.bcci_rsp_data),
    .rd_addr (rd_ptr_q),
    .rd_dat  (head_dat)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      col_d    = '0;
      row_d    = '0;
    end else begin
      if (push_vld) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_vld) begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        frame_done_d = head_eof;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + row_t'(1);
        end else begin
          col_d = col_q + col_t'(1);
        end
      end
      case ({push_vld, pop_vld})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.bf_rsp_ready  = ~full;
  assign bus.upsp_ac_wrt   = head_vld;
  assign bus.upsp_ac_wdata = head_vld ? head_dat : '0;
  assign bus.upsp_ac_eol   = head_eol;
  assign bus.upsp_ac_eof   = head_eof;
  assign frame_done        = frame_done_q;
  assign fifo_level        = level_q;

`ifdef OUTFIFO_STAT_EN
  logic [LVL_W-1:0] hwm_q, hwm_d;
  logic [31:0]      stall_q, stall_d;

  // Compare against next level so the mark tracks fifo_level in the same cycle.
  always_comb begin
    hwm_d   = (level_d > hwm_q) ? level_d : hwm_q;
    stall_d = stall_q;
    if (head_vld & ~bus.ac_upsp_wready & (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush) begin
      hwm_d   = '0;
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      hwm_q   <= hwm_d;
      stall_q <= stall_d;
    end
  end

  assign fifo_hwm  = hwm_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_upsp_out_fifo.sv
// Bench for upsp_out_fifo on a 4x2 destination frame with a 16-deep FIFO.
module tb_upsp_out_fifo;

  import upsp_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             frame_done;
  logic [LVL_W-1:0] fifo_level;
`ifdef OUTFIFO_STAT_EN
  logic [LVL_W-1:0] fifo_hwm;
  logic [31:0]      stall_cnt;
`endif

  upsp_out_fifo_if #(.DW(DW)) bus ();

  upsp_out_fifo #(
    .UPSP_DATA_WIDTH (DW),
    .FIFO_DEPTH      (DEPTH),
    .DST_IMG_WIDTH   (W),
    .DST_IMG_HEIGHT  (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
`ifdef OUTFIFO_STAT_EN
    ,
    .fifo_hwm   (fifo_hwm),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of pending pixels plus the destination raster position.
  logic [DW-1:0] mq[$];
  int            m_col   = 0;
  int            m_row   = 0;
  bit            m_fd    = 1'b0;
  int            m_hwm   = 0;
  longint        m_stall = 0;

  typedef struct {
    bit          v;
    logic [23:0] d;
    bit          wr;
    bit          fl;
    bit          e_rdy;
    bit          e_wrt;
    logic [23:0] e_dat;
    bit          e_eol;
    bit          e_eof;
    bit          e_fd;
    int          e_lvl;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(bit v, logic [23:0] d, bit wr, bit fl, bit rdy, bit wrt,
                              logic [23:0] dat, bit eol, bit eof, bit fd, int lvl);
    vec_t r;
    r.v = v; r.d = d; r.wr = wr; r.fl = fl;
    r.e_rdy = rdy; r.e_wrt = wrt; r.e_dat = dat; r.e_eol = eol; r.e_eof = eof;
    r.e_fd = fd; r.e_lvl = lvl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit            wrt;
    bit            eol;
    bit            eof;
    logic [DW-1:0] hd;
    wrt = (mq.size() != 0);
    hd  = '0;
    if (wrt) hd = mq[0];
    eol = wrt && (m_col == W - 1);
    eof = eol && (m_row == H - 1);
    chk("ready",      32'(bus.bf_rsp_ready), 32'(mq.size() < DEPTH));
    chk("wrt",        32'(bus.upsp_ac_wrt),  32'(wrt));
    chk("wdata",      32'(bus.upsp_ac_wdata), 32'(hd));
    chk("eol",        32'(bus.upsp_ac_eol),  32'(eol));
    chk("eof",        32'(bus.upsp_ac_eof),  32'(eof));
    chk("frame_done", 32'(frame_done),       32'(m_fd));
    chk("level",      32'(fifo_level),       32'(mq.size()));
`ifdef OUTFIFO_STAT_EN
    chk("hwm",        32'(fifo_hwm),         32'(m_hwm));
    chk("stall_cnt",  stall_cnt,             32'(m_stall));
`endif
  endtask

  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit wr, input bit fl);
    bit can_push;
    bit can_pop;
    if (fl) begin
      mq.delete();
      m_col = 0; m_row = 0; m_fd = 1'b0; m_hwm = 0; m_stall = 0;
      return;
    end
    can_push = v && (mq.size() < DEPTH);
    can_pop  = (mq.size() > 0) && wr;
    m_fd = 1'b0;
    if (mq.size() > 0 && !wr && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (can_pop) begin
      if (m_col == W - 1 && m_row == H - 1) m_fd = 1'b1;
      void'(mq.pop_front());
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row + 1) % H;
      end
    end
    if (can_push) mq.push_back(d);
    if (mq.size() > m_hwm) m_hwm = mq.size();
  endtask

  // One clock: check the current DUT state against the model, then apply new inputs.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit wr, input bit fl);
    @(negedge clk);
    check_model();
    bus.bcci_rsp_valid = v;
    bus.bcci_rsp_data  = d;
    bus.ac_upsp_wready = wr;
    flush              = fl;
    model_step(v, d, wr, fl);
  endtask

  function automatic logic [DW-1:0] rnd_pix();
    upsp_pix_t p;
    p.r = 8'($urandom);
    p.g = 8'($urandom);
    p.b = 8'($urandom);
    return DW'(p);
  endfunction

  initial begin
    int fd_seen;
    int eol_seen;
    int eof_seen;
    rst_n              = 1'b0;
    flush              = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    bus.bcci_rsp_data  = '0;
    bus.ac_upsp_wready = 1'b0;

    tv[0]  = mk(1, 24'h0000A1, 1, 0,  1, 1, 24'h0000A1, 0, 0, 0, 1);
    tv[1]  = mk(1, 24'h0000B2, 1, 0,  1, 1, 24'h0000B2, 0, 0, 0, 1);
    tv[2]  = mk(1, 24'h0000C3, 1, 0,  1, 1, 24'h0000C3, 0, 0, 0, 1);
    tv[3]  = mk(1, 24'h0000D4, 1, 0,  1, 1, 24'h0000D4, 1, 0, 0, 1);
    tv[4]  = mk(1, 24'h0000E5, 1, 0,  1, 1, 24'h0000E5, 0, 0, 0, 1);
    tv[5]  = mk(0, 24'h000000, 1, 0,  1, 0, 24'h000000, 0, 0, 0, 0);
    tv[6]  = mk(1, 24'h0000F6, 0, 0,  1, 1, 24'h0000F6, 0, 0, 0, 1);
    tv[7]  = mk(1, 24'h000017, 0, 0,  1, 1, 24'h0000F6, 0, 0, 0, 2);
    tv[8]  = mk(0, 24'h000000, 0, 0,  1, 1, 24'h0000F6, 0, 0, 0, 2);
    tv[9]  = mk(1, 24'h000028, 1, 0,  1, 1, 24'h000017, 0, 0, 0, 2);
    tv[10] = mk(0, 24'h000000, 1, 0,  1, 1, 24'h000028, 1, 1, 0, 1);
    tv[11] = mk(0, 24'h000000, 1, 0,  1, 0, 24'h000000, 0, 0, 1, 0);
    tv[12] = mk(1, 24'h000039, 1, 1,  1, 0, 24'h000000, 0, 0, 0, 0);
    tv[13] = mk(0, 24'h000000, 1, 0,  1, 0, 24'h000000, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(bus.bf_rsp_ready),  32'd1);
    chk("rst wrt",   32'(bus.upsp_ac_wrt),   32'd0);
    chk("rst wdata", 32'(bus.upsp_ac_wdata), 32'd0);
    chk("rst eol",   32'(bus.upsp_ac_eol),   32'd0);
    chk("rst eof",   32'(bus.upsp_ac_eof),   32'd0);
    chk("rst fd",    32'(frame_done),        32'd0);
    chk("rst level", 32'(fifo_level),        32'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.bcci_rsp_valid = tv[i].v;
      bus.bcci_rsp_data  = tv[i].d;
      bus.ac_upsp_wready = tv[i].wr;
      flush              = tv[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d ready", i), 32'(bus.bf_rsp_ready),  32'(tv[i].e_rdy));
      chk($sformatf("tv%0d wrt", i),   32'(bus.upsp_ac_wrt),   32'(tv[i].e_wrt));
      chk($sformatf("tv%0d wdata", i), 32'(bus.upsp_ac_wdata), 32'(tv[i].e_dat));
      chk($sformatf("tv%0d eol", i),   32'(bus.upsp_ac_eol),   32'(tv[i].e_eol));
      chk($sformatf("tv%0d eof", i),   32'(bus.upsp_ac_eof),   32'(tv[i].e_eof));
      chk($sformatf("tv%0d fd", i),    32'(frame_done),        32'(tv[i].e_fd));
      chk($sformatf("tv%0d level", i), 32'(fifo_level),        32'(tv[i].e_lvl));
    end

    // Fill past full with the consumer stalled, then drain in order
    for (int i = 0; i < 17; i++) cyc(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    chk("full level", 32'(fifo_level),       32'd16);
    chk("full ready", 32'(bus.bf_rsp_ready), 32'd0);
    cyc(1'b1, DW'(32'h110), 1'b1, 1'b0);
    cyc(1'b1, DW'(32'h110), 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drained level", 32'(fifo_level), 32'd0);

    // One full 4x2 frame streamed straight through
    cyc(1'b0, '0, 1'b1, 1'b1);
    fd_seen = 0; eol_seen = 0; eof_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc((i < 8), DW'(32'h200 + i), 1'b1, 1'b0);
      if (frame_done === 1'b1) fd_seen++;
      if (bus.upsp_ac_wrt === 1'b1 && bus.upsp_ac_eol === 1'b1) eol_seen++;
      if (bus.upsp_ac_wrt === 1'b1 && bus.upsp_ac_eof === 1'b1) eof_seen++;
    end
    chk("frame eol count", 32'(eol_seen), 32'd2);
    chk("frame eof count", 32'(eof_seen), 32'd1);
    chk("frame_done pulses", 32'(fd_seen), 32'd1);

    // Steady push+pop at level 8
    cyc(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(32'h310 + i), 1'b1, 1'b0);
    chk("steady level", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush at level 5 with a pixel offered, then realigned raster
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(32'h400 + i), 1'b0, 1'b0);
    cyc(1'b1, DW'(32'h4FF), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("post-flush wrt",   32'(bus.upsp_ac_wrt), 32'd0);
    chk("post-flush level", 32'(fifo_level),      32'd0);
    for (int i = 0; i < 11; i++) cyc((i < 8), DW'(32'h500 + i), 1'b1, 1'b0);

`ifdef OUTFIFO_STAT_EN
    // Ten stalled cycles with a non-empty FIFO; peak occupancy 3
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, DW'(32'h600), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc((i < 2), DW'(32'h601 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stall_cnt 10", stall_cnt,         32'd10);
    chk("hwm peak",     32'(fifo_hwm),     32'd3);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
`endif

    // Randomised traffic in three consumer-throughput regimes
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        bit v;
        bit wr;
        bit fl;
        v  = ($urandom_range(0, 3) != 0);
        case (ph)
          0:       wr = ($urandom_range(0, 3) != 0);
          1:       wr = ($urandom_range(0, 3) == 0);
          default: wr = ($urandom_range(0, 1) == 0);
        endcase
        fl = ($urandom_range(0, 199) == 0);
        cyc(v, rnd_pix(), wr, fl);
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
